// File: rtl/camera_init_sequencer.sv
// Camera register-initialisation sequencer: walks a synchronous ROM table and
// drives one i2c_control instance with register writes, read-back and retries.
module camera_init_sequencer #(
  parameter int unsigned LUT_SIZE     = 256,
  parameter logic [7:0]  DEVICE_ID    = 8'h78,
  parameter bit          ADDR_MODE    = 1'b1,
  parameter int unsigned PWRUP_CYCLES = 1_000_000,
  parameter int unsigned DLY_UNIT     = 50_000,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [31:0] GAP_CYCLES   = 32'd5000,
  localparam int unsigned IW          = (LUT_SIZE > 1) ? $clog2(LUT_SIZE) : 1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          start,
  input  logic          verify_en,
  output logic [IW-1:0] lut_index,
  input  logic [23:0]   lut_data,
  output logic          wrreg_req,
  output logic          rdreg_req,
  output logic [15:0]   addr,
  output logic          addr_mode,
  output logic [7:0]    wrdata,
  output logic [7:0]    device_id,
  output logic [31:0]   dly_cnt_max,
  input  logic [7:0]    rddata,
  input  logic          RW_Done,
  input  logic          ack,
  output logic          busy,
  output logic          init_done,
  output logic          init_error,
  output logic [IW-1:0] err_index,
  output logic [3:0]    dbg_state
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PWR_WAIT = 4'd1;
  localparam logic [3:0] S_FETCH    = 4'd2;
  localparam logic [3:0] S_LATCH    = 4'd3;
  localparam logic [3:0] S_WR_REQ   = 4'd4;
  localparam logic [3:0] S_WR_WAIT  = 4'd5;
  localparam logic [3:0] S_RD_REQ   = 4'd6;
  localparam logic [3:0] S_RD_WAIT  = 4'd7;
  localparam logic [3:0] S_CHECK    = 4'd8;
  localparam logic [3:0] S_DLY      = 4'd9;
  localparam logic [3:0] S_NEXT     = 4'd10;
  localparam logic [3:0] S_DONE     = 4'd11;
  localparam logic [3:0] S_ERROR    = 4'd12;

  localparam logic [15:0] DLY_MARKER = 16'hFFFF;

  logic [3:0]    state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [IW-1:0] index_q, index_d;
  logic [31:0]   retry_q, retry_d;
  logic [23:0]   entry_q, entry_d;
  logic          verify_q, verify_d;
  logic          rd_ack_q, rd_ack_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic [IW-1:0] err_index_q, err_index_d;

  logic [31:0]   dly_prod;
  logic          last_entry;
  logic          fail_access;

  // Delay markers carry the unit count in the data byte; product wraps at 32 bits.
  assign dly_prod   = {24'd0, entry_q[7:0]} * DLY_UNIT;
  assign last_entry = (index_q == IW'(LUT_SIZE - 1));

  // Handshake with i2c_control: a request is a single-cycle pulse issued only
  // from WR_REQ/RD_REQ; the access is complete on the one-cycle RW_Done pulse,
  // with ack (1 = NACK seen) qualified by RW_Done. RW_Done elsewhere is ignored.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    index_d     = index_q;
    retry_d     = retry_q;
    entry_d     = entry_q;
    verify_d    = verify_q;
    rd_ack_d    = rd_ack_q;
    rd_data_d   = rd_data_q;
    err_index_d = err_index_q;
    fail_access = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d     = S_PWR_WAIT;
          cnt_d       = 32'd0;
          index_d     = '0;
          retry_d     = 32'd0;
          err_index_d = '0;
          verify_d    = verify_en;
        end
      end

      S_PWR_WAIT: begin
        if ((cnt_q + 32'd1) >= PWRUP_CYCLES) begin
          state_d = S_FETCH;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_FETCH: state_d = S_LATCH;

      S_LATCH: begin
        entry_d = lut_data;
        cnt_d   = 32'd0;
        state_d = (lut_data[23:8] == DLY_MARKER) ? S_DLY : S_WR_REQ;
      end

      S_DLY: begin
        // A zero-unit marker still spends exactly one cycle here.
        if ((cnt_q + 32'd1) >= dly_prod) begin
          state_d = S_NEXT;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_WR_REQ: state_d = S_WR_WAIT;

      S_WR_WAIT: begin
        if (RW_Done) begin
          if (ack) begin
            fail_access = 1'b1;
          end else if (verify_q) begin
            state_d = S_RD_REQ;
          end else begin
            state_d = S_NEXT;
          end
        end
      end

      S_RD_REQ: state_d = S_RD_WAIT;

      S_RD_WAIT: begin
        if (RW_Done) begin
          rd_ack_d  = ack;
          rd_data_d = rddata;
          state_d   = S_CHECK;
        end
      end

      S_CHECK: begin
        if (rd_ack_q || (rd_data_q != entry_q[7:0])) begin
          fail_access = 1'b1;
        end else begin
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        retry_d = 32'd0;
        if (last_entry) begin
          state_d = S_DONE;
        end else begin
          index_d = index_q + IW'(1);
          state_d = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (fail_access) begin
      if (retry_q < MAX_RETRY) begin
        retry_d = retry_q + 32'd1;
        state_d = S_WR_REQ;
      end else begin
        err_index_d = index_q;
        state_d     = S_ERROR;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 32'd0;
      index_q     <= '0;
      retry_q     <= 32'd0;
      entry_q     <= 24'd0;
      verify_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_data_q   <= 8'd0;
      err_index_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      index_q     <= index_d;
      retry_q     <= retry_d;
      entry_q     <= entry_d;
      verify_q    <= verify_d;
      rd_ack_q    <= rd_ack_d;
      rd_data_q   <= rd_data_d;
      err_index_q <= err_index_d;
    end
  end

  // In 8-bit address mode only the low byte of the table address is meaningful.
  assign addr        = ADDR_MODE ? entry_q[23:8] : {8'd0, entry_q[15:8]};
  assign wrdata      = entry_q[7:0];
  assign lut_index   = index_q;
  assign err_index   = err_index_q;
  assign wrreg_req   = (state_q == S_WR_REQ);
  assign rdreg_req   = (state_q == S_RD_REQ);
  assign init_done   = (state_q == S_DONE);
  assign init_error  = (state_q == S_ERROR);
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
  assign addr_mode   = ADDR_MODE;
  assign device_id   = DEVICE_ID;
  assign dly_cnt_max = GAP_CYCLES;
  assign dbg_state   = state_q;

endmodule
